// File: rtl/gemm_tile_scheduler.sv
// Tile-level address/strobe sequencer for the RowPar x ColPar output-stationary GeMM array.
// Optional GEMM_SCHED_PERF_EN adds perf_cycles_o, the busy-cycle count of the last job.
module gemm_tile_scheduler #(
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned RowPar        = 4,
    parameter int unsigned ColPar        = 16,
    parameter int unsigned PerfWidth     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     pe_valid_o,
    output logic                     pe_init_o,
    output logic                     sram_c_we_o,
    output logic [RowPar-1:0]        row_mask_o,
    output logic [ColPar-1:0]        col_mask_o,
    output logic                     busy_o,
    output logic                     done_o
`ifdef GEMM_SCHED_PERF_EN
    ,
    output logic [PerfWidth-1:0]     perf_cycles_o
`endif
);

    localparam int unsigned SW = SizeAddrWidth;
    localparam int unsigned TW = SizeAddrWidth + 1;
    localparam int unsigned MW = TW + $clog2(RowPar) + $clog2(ColPar) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_n;

    logic [SW-1:0] m_q, k_q, n_q;
    logic [TW-1:0] mt_q, nt_q;
    logic [SW-1:0] kk_q;

    logic [SW-1:0] sz_m, sz_k, sz_n;
    logic [TW-1:0] mtiles, ntiles;
    logic [TW-1:0] iss_mt, iss_nt, mt_n, nt_n;
    logic [SW-1:0] iss_k, kk_n;
    logic          last_k, last_nt, last_mt, last_issue;
    logic          accept, zero_size, issue, busy_n;
    logic [AddrWidth-1:0] a_addr_c, b_addr_c, c_addr_c;
    logic [RowPar-1:0]    row_c;
    logic [ColPar-1:0]    col_c;

    // Pipeline: stage0 = SRAM address, stage1 = PE strobes, stage2 = C write
    logic                 v0_q, init0_q, last0_q, fin0_q;
    logic [AddrWidth-1:0] c0_q, c1_q;
    logic [RowPar-1:0]    rm0_q, rm1_q;
    logic [ColPar-1:0]    cm0_q, cm1_q;
    logic                 last1_q, fin1_q, fin2_q;

    // In IDLE the first issue is taken straight from the ports so it lands in cycle 1
    always_comb begin
        sz_m   = m_q;
        sz_k   = k_q;
        sz_n   = n_q;
        iss_mt = mt_q;
        iss_nt = nt_q;
        iss_k  = kk_q;
        if (state == IDLE) begin
            sz_m   = M_size_i;
            sz_k   = K_size_i;
            sz_n   = N_size_i;
            iss_mt = '0;
            iss_nt = '0;
            iss_k  = '0;
        end
        mtiles = (TW'(sz_m) + TW'(RowPar - 1)) / TW'(RowPar);
        ntiles = (TW'(sz_n) + TW'(ColPar - 1)) / TW'(ColPar);

        last_k     = (iss_k == sz_k - SW'(1));
        last_nt    = (iss_nt == ntiles - TW'(1));
        last_mt    = (iss_mt == mtiles - TW'(1));
        last_issue = last_k && last_nt && last_mt;

        accept    = (state == IDLE) && start_i;
        zero_size = (sz_m == '0) || (sz_k == '0) || (sz_n == '0);
        issue     = (accept && !zero_size) || (state == RUN);

        kk_n = last_k ? '0 : iss_k + SW'(1);
        nt_n = last_k ? (last_nt ? '0 : iss_nt + TW'(1)) : iss_nt;
        mt_n = (last_k && last_nt) ? iss_mt + TW'(1) : iss_mt;

        a_addr_c = AddrWidth'(iss_mt) * AddrWidth'(sz_k) + AddrWidth'(iss_k);
        b_addr_c = AddrWidth'(iss_nt) * AddrWidth'(sz_k) + AddrWidth'(iss_k);
        c_addr_c = AddrWidth'(iss_mt) * AddrWidth'(ntiles) + AddrWidth'(iss_nt);

        for (int r = 0; r < RowPar; r++) begin
            row_c[r] = (MW'(iss_mt) * MW'(RowPar) + MW'(r)) < MW'(sz_m);
        end
        for (int c = 0; c < ColPar; c++) begin
            col_c[c] = (MW'(iss_nt) * MW'(ColPar) + MW'(c)) < MW'(sz_n);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (zero_size)       state_n = DONE;
                    else if (last_issue) state_n = DRAIN;
                    else                 state_n = RUN;
                end
            end
            RUN:     if (last_issue) state_n = DRAIN;
            DRAIN:   if (fin2_q) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN) || (state_n == DRAIN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m_q <= '0; k_q <= '0; n_q <= '0;
            mt_q <= '0; nt_q <= '0; kk_q <= '0;
            v0_q <= 1'b0; init0_q <= 1'b0; last0_q <= 1'b0; fin0_q <= 1'b0;
            c0_q <= '0; rm0_q <= '0; cm0_q <= '0;
            c1_q <= '0; rm1_q <= '0; cm1_q <= '0;
            last1_q <= 1'b0; fin1_q <= 1'b0; fin2_q <= 1'b0;
            sram_a_addr_o <= '0; sram_b_addr_o <= '0; sram_c_addr_o <= '0;
            pe_valid_o <= 1'b0; pe_init_o <= 1'b0; sram_c_we_o <= 1'b0;
            row_mask_o <= '0; col_mask_o <= '0;
            busy_o <= 1'b0; done_o <= 1'b0;
        end else begin
            if (accept) begin
                m_q <= M_size_i;
                k_q <= K_size_i;
                n_q <= N_size_i;
            end
            v0_q    <= issue;
            init0_q <= issue && (iss_k == '0);
            last0_q <= issue && last_k;
            fin0_q  <= issue && last_issue;
            if (issue) begin
                mt_q <= mt_n;
                nt_q <= nt_n;
                kk_q <= kk_n;
                sram_a_addr_o <= a_addr_c;
                sram_b_addr_o <= b_addr_c;
                c0_q  <= c_addr_c;
                rm0_q <= row_c;
                cm0_q <= col_c;
            end
            pe_valid_o <= v0_q;
            pe_init_o  <= v0_q && init0_q;
            last1_q    <= last0_q;
            fin1_q     <= fin0_q;
            c1_q       <= c0_q;
            rm1_q      <= rm0_q;
            cm1_q      <= cm0_q;
            // C write lands one cycle after the tile's last valid K step
            sram_c_we_o <= last1_q;
            fin2_q      <= fin1_q;
            if (last1_q) begin
                sram_c_addr_o <= c1_q;
                row_mask_o    <= rm1_q;
                col_mask_o    <= cm1_q;
            end
            busy_o <= busy_n;
            done_o <= (state_n == DONE);
        end
    end

`ifdef GEMM_SCHED_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)     perf_cycles_o <= '0;
        else if (accept) perf_cycles_o <= PerfWidth'(busy_n);
        else             perf_cycles_o <= perf_cycles_o + PerfWidth'(busy_n);
    end
`else
    // PerfWidth has no effect without the cycle counter
    if (PerfWidth == 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler: stimulus pushes expected events, a monitor pops them.
// Define GEMM_SCHED_PERF_EN for both files to also check perf_cycles_o.
module tb_gemm_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  M_size_i = '0, K_size_i = '0, N_size_i = '0;
    logic [15:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic        pe_valid_o, pe_init_o, sram_c_we_o, busy_o, done_o;
    logic [3:0]  row_mask_o;
    logic [15:0] col_mask_o;
`ifdef GEMM_SCHED_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    gemm_tile_scheduler dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
        .sram_a_addr_o(sram_a_addr_o), .sram_b_addr_o(sram_b_addr_o),
        .sram_c_addr_o(sram_c_addr_o), .pe_valid_o(pe_valid_o),
        .pe_init_o(pe_init_o), .sram_c_we_o(sram_c_we_o),
        .row_mask_o(row_mask_o), .col_mask_o(col_mask_o),
        .busy_o(busy_o), .done_o(done_o)
`ifdef GEMM_SCHED_PERF_EN
        , .perf_cycles_o(perf_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int a; int b; int init;} vexp_t;
    typedef struct {int cyc; int c; int rm; int cm;} wexp_t;
    vexp_t q_valid[$];
    wexp_t q_write[$];
    int    q_done[$];
    int    busy_from = 1, busy_to = 0;
    int    n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe
    logic [15:0] prev_a = '0, prev_b = '0;
    always @(negedge clk) begin
        vexp_t ve;
        wexp_t we;
        int    dc;
        if (pe_init_o && !pe_valid_o) check("init_without_valid", 32'(pe_init_o), 32'd0);
        if (pe_valid_o) begin
            if (q_valid.size() == 0) check("unexpected_valid", 32'(pe_valid_o), 32'd0);
            else begin
                ve = q_valid.pop_front();
                check("valid_cycle", 32'(cyc), 32'(ve.cyc));
                check("a_addr", 32'(prev_a), 32'(ve.a));
                check("b_addr", 32'(prev_b), 32'(ve.b));
                check("pe_init", 32'(pe_init_o), 32'(ve.init));
            end
        end
        if (sram_c_we_o) begin
            if (q_write.size() == 0) check("unexpected_write", 32'(sram_c_we_o), 32'd0);
            else begin
                we = q_write.pop_front();
                check("write_cycle", 32'(cyc), 32'(we.cyc));
                check("c_addr", 32'(sram_c_addr_o), 32'(we.c));
                check("row_mask", 32'(row_mask_o), 32'(we.rm));
                check("col_mask", 32'(col_mask_o), 32'(we.cm));
            end
        end
        if (done_o) begin
            if (q_done.size() == 0) check("unexpected_done", 32'(done_o), 32'd0);
            else begin
                dc = q_done.pop_front();
                check("done_cycle", 32'(cyc), 32'(dc));
            end
        end
        check("busy", 32'(busy_o), 32'(cyc >= busy_from && cyc <= busy_to));
        prev_a = sram_a_addr_o;
        prev_b = sram_b_addr_o;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 32'(sram_a_addr_o), 32'd0);
        check({tag, "_b"}, 32'(sram_b_addr_o), 32'd0);
        check({tag, "_c"}, 32'(sram_c_addr_o), 32'd0);
        check({tag, "_strobes"}, 32'({pe_valid_o, pe_init_o, sram_c_we_o, busy_o, done_o}), 32'd0);
        check({tag, "_masks"}, 32'({row_mask_o, col_mask_o}), 32'd0);
`ifdef GEMM_SCHED_PERF_EN
        check({tag, "_perf"}, perf_cycles_o, 32'd0);
`endif
    endtask

    // Reference model: nested tile/K loops, events past 'cut' are dropped
    task automatic model_push(input int m, input int k, input int n, input int t0, input int cut);
        int mtl, ntl, c, j, t;
        vexp_t ve;
        wexp_t we;
        mtl = (m + 3) / 4;
        ntl = (n + 15) / 16;
        busy_from = t0 + 1;
        if (m == 0 || k == 0 || n == 0) begin
            if (t0 + 1 <= cut) q_done.push_back(t0 + 1);
            busy_to = t0;
            return;
        end
        t = mtl * ntl * k;
        c = 1;
        j = 0;
        for (int mt = 0; mt < mtl; mt++) begin
            for (int nt = 0; nt < ntl; nt++) begin
                for (int kk = 0; kk < k; kk++) begin
                    ve.cyc = t0 + c + 1;
                    ve.a = (mt * k + kk) % 65536;
                    ve.b = (nt * k + kk) % 65536;
                    ve.init = (kk == 0) ? 1 : 0;
                    if (ve.cyc <= cut) q_valid.push_back(ve);
                    c++;
                end
                we.cyc = t0 + 2 + (j + 1) * k;
                we.c = (mt * ntl + nt) % 65536;
                we.rm = 0;
                we.cm = 0;
                for (int r = 0; r < 4; r++)  if (mt * 4 + r < m)  we.rm |= (1 << r);
                for (int q = 0; q < 16; q++) if (nt * 16 + q < n) we.cm |= (1 << q);
                if (we.cyc <= cut) q_write.push_back(we);
                j++;
            end
        end
        if (t0 + t + 3 <= cut) q_done.push_back(t0 + t + 3);
        busy_to = (t0 + t + 2 < cut) ? t0 + t + 2 : cut;
    endtask

    // Hand-computed: M=4 K=3 N=16
    task automatic hand1(input int t0);
        vexp_t ve;
        wexp_t we;
        for (int i = 0; i < 3; i++) begin
            ve.cyc = t0 + 2 + i; ve.a = i; ve.b = i; ve.init = (i == 0) ? 1 : 0;
            q_valid.push_back(ve);
        end
        we.cyc = t0 + 5; we.c = 0; we.rm = 'hF; we.cm = 'hFFFF;
        q_write.push_back(we);
        q_done.push_back(t0 + 6);
        busy_from = t0 + 1;
        busy_to = t0 + 5;
    endtask

    // Hand-computed: M=8 K=2 N=32
    task automatic hand2(input int t0);
        int a_seq[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        int b_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        vexp_t ve;
        wexp_t we;
        for (int i = 0; i < 8; i++) begin
            ve.cyc = t0 + 2 + i; ve.a = a_seq[i]; ve.b = b_seq[i]; ve.init = (i % 2 == 0) ? 1 : 0;
            q_valid.push_back(ve);
        end
        for (int i = 0; i < 4; i++) begin
            we.cyc = t0 + 4 + 2 * i; we.c = i; we.rm = 'hF; we.cm = 'hFFFF;
            q_write.push_back(we);
        end
        q_done.push_back(t0 + 11);
        busy_from = t0 + 1;
        busy_to = t0 + 10;
    endtask

    // ss1/ss2: relative cycles of extra start pulses; rst_rel: relative cycle with rst_ni low
    task automatic run_job(input int m, input int k, input int n, input int ss1, input int ss2,
                           input int rst_rel, input int hand_id);
        int t0, t, total, rel;
        @(negedge clk);
        M_size_i = 8'(m); K_size_i = 8'(k); N_size_i = 8'(n);
        start_i = 1'b1;
        t0 = cyc;
        case (hand_id)
            1:       hand1(t0);
            2:       hand2(t0);
            default: model_push(m, k, n, t0, (rst_rel < 0) ? 32'h7fff_ffff : t0 + rst_rel);
        endcase
        t = (m == 0 || k == 0 || n == 0) ? 0 : ((m + 3) / 4) * ((n + 15) / 16) * k;
        total = t + 6;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            start_i = (rel == ss1 || rel == ss2);
            M_size_i = 8'(rel * 37 + 5); K_size_i = 8'(rel * 11 + 1); N_size_i = 8'(rel * 53 + 3);
            if (rel == rst_rel) rst_ni = 1'b0;
            if (rst_rel >= 0 && rel == rst_rel + 1) begin
                check_all_zero("mid_reset");
                rst_ni = 1'b1;
            end
        end
        start_i = 1'b0;
        check("pending_valid", 32'(q_valid.size()), 32'd0);
        check("pending_write", 32'(q_write.size()), 32'd0);
        check("pending_done", 32'(q_done.size()), 32'd0);
`ifdef GEMM_SCHED_PERF_EN
        if (rst_rel < 0) check("perf_cycles", perf_cycles_o, 32'((t == 0) ? 0 : t + 2));
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_ni = 1'b1;
        run_job(4, 3, 16, -1, -1, -1, 1);
        run_job(8, 2, 32, 3, 11, -1, 2);
        run_job(5, 1, 17, -1, -1, -1, 0);
        run_job(4, 0, 16, 1, -1, -1, 0);
        run_job(0, 3, 16, -1, -1, -1, 0);
        run_job(8, 2, 32, -1, -1, 3, 0);
        run_job(8, 2, 32, -1, -1, -1, 2);
        run_job(255, 2, 16, -1, -1, -1, 0);
        run_job(3, 1, 40, -1, -1, -1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
